// File: rtl/ff_bank_cfg.sv
// ff_bank_cfg: CH independent W-bit, DEPTH-stage register pipelines with per-channel
// runtime-selectable flop mode (plain / enable / sync-reset / sync-reset+enable).
`default_nettype none

module ff_bank_cfg #(
  parameter int             CH       = 4,
  parameter int             W        = 8,
  parameter int             DEPTH    = 2,
  parameter logic           EN_POL   = 1'b1,
  parameter logic           SRST_POL = 1'b1,
  parameter logic [W-1:0]   SRST_VAL = '0,
  parameter logic [W-1:0]   INIT_VAL = '0,
  parameter logic [2:0]     MODE_RST = 3'd1,
  localparam int            CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              C,
  input  logic              R,
  input  logic [CH*W-1:0]   D,
  input  logic [CH-1:0]     E,
  input  logic [CH-1:0]     S,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [2:0]        cfg_mode,
  output logic [CH*W-1:0]   Q,
  output logic [CH-1:0]     V,
  output logic [CH*3-1:0]   MODE
);

  localparam logic [2:0] MODE_DFF    = 3'd0;
  localparam logic [2:0] MODE_DFFE   = 3'd1;
  localparam logic [2:0] MODE_SDFF   = 3'd2;
  localparam logic [2:0] MODE_SDFFE  = 3'd3;
  localparam logic [2:0] MODE_SDFFCE = 3'd4;

  localparam logic [DEPTH-1:0] VLD_IN = DEPTH'(1);

  logic [2:0] mode_q [CH];
  logic [2:0] mode_d [CH];

  // Out-of-range channel numbers simply match no channel and are dropped.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      mode_d[k] = mode_q[k];
      if (cfg_we && (int'(cfg_ch) == k)) begin
        mode_d[k] = cfg_mode;
      end
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      for (int k = 0; k < CH; k++) begin
        mode_q[k] <= MODE_RST;
      end
    end else begin
      for (int k = 0; k < CH; k++) begin
        mode_q[k] <= mode_d[k];
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic             en_act;
    logic             srst_act;
    logic             adv;
    logic             srst;
    logic [W-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    assign en_act   = (E[k] == EN_POL);
    assign srst_act = (S[k] == SRST_POL);

    always_comb begin
      adv  = 1'b0;
      srst = 1'b0;
      case (mode_q[k])
        MODE_DFF:    adv = 1'b1;
        MODE_DFFE:   adv = en_act;
        MODE_SDFF: begin
          adv  = 1'b1;
          srst = srst_act;
        end
        MODE_SDFFE: begin
          adv  = en_act;
          srst = srst_act;
        end
        MODE_SDFFCE: begin
          adv  = en_act;
          srst = srst_act & en_act;
        end
        default: begin
          adv  = 1'b0;
          srst = 1'b0;
        end
      endcase
    end

    // Sync reset takes precedence over advance; a hold stalls every stage together.
    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= INIT_VAL;
        end
        vld_q <= '0;
      end else if (srst) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= SRST_VAL;
        end
        vld_q <= '0;
      end else if (adv) begin
        data_q[0] <= D[k*W +: W];
        for (int i = 1; i < DEPTH; i++) begin
          data_q[i] <= data_q[i-1];
        end
        vld_q <= (vld_q << 1) | VLD_IN;
      end
    end

    assign Q[k*W +: W] = data_q[DEPTH-1];
    assign V[k]        = vld_q[DEPTH-1];
    assign MODE[k*3 +: 3] = mode_q[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_ff_bank_cfg.sv
// Self-checking bench for ff_bank_cfg: directed scenarios on a default build, then
// randomized traffic on the default build and an inverted-polarity build vs a model.
`default_nettype none

module tb_ff_bank_cfg;

  logic C = 1'b0;
  logic R = 1'b0;
  always #5 C = ~C;

  // Default build: CH=4, W=8, DEPTH=2, active-high E/S, SRST_VAL=0, INIT_VAL=0, MODE_RST=1
  logic [31:0] d0;
  logic [3:0]  e0, s0;
  logic        we0;
  logic [1:0]  ch0;
  logic [2:0]  md0;
  logic [31:0] q0;
  logic [3:0]  v0;
  logic [11:0] mo0;

  // Alternate build: CH=3, W=6, DEPTH=3, active-low E/S, SRST_VAL=2A, INIT_VAL=15, MODE_RST=0
  logic [17:0] d1;
  logic [2:0]  e1, s1;
  logic        we1;
  logic [1:0]  ch1;
  logic [2:0]  md1;
  logic [17:0] q1;
  logic [2:0]  v1;
  logic [8:0]  mo1;

  ff_bank_cfg u_dut (
    .C(C), .R(R), .D(d0), .E(e0), .S(s0),
    .cfg_we(we0), .cfg_ch(ch0), .cfg_mode(md0),
    .Q(q0), .V(v0), .MODE(mo0)
  );

  ff_bank_cfg #(
    .CH(3), .W(6), .DEPTH(3), .EN_POL(1'b0), .SRST_POL(1'b0),
    .SRST_VAL(6'h2A), .INIT_VAL(6'h15), .MODE_RST(3'd0)
  ) u_alt (
    .C(C), .R(R), .D(d1), .E(e1), .S(s1),
    .cfg_we(we1), .cfg_ch(ch1), .cfg_mode(md1),
    .Q(q1), .V(v1), .MODE(mo1)
  );

  int checks = 0;
  int errors = 0;

  // Per-build parameters for the reference model
  int p_ch   [2] = '{4, 3};
  int p_w    [2] = '{8, 6};
  int p_dep  [2] = '{2, 3};
  bit p_en   [2] = '{1'b1, 1'b0};
  bit p_sr   [2] = '{1'b1, 1'b0};
  int p_srv  [2] = '{'h00, 'h2A};
  int p_init [2] = '{'h00, 'h15};
  int p_mrst [2] = '{1, 0};

  // Model state: stage contents (index 0 = newest), advances since last reset, mode
  int m_st   [2][4][3];
  int m_cnt  [2][4];
  int m_mode [2][4];

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic model_reset(input int b);
    for (int k = 0; k < 4; k++) begin
      m_mode[b][k] = p_mrst[b];
      m_cnt[b][k]  = 0;
      for (int i = 0; i < 3; i++) m_st[b][k][i] = p_init[b];
    end
  endtask

  task automatic model_step(input int b, input logic [31:0] d, input logic [3:0] e,
                            input logic [3:0] s, input logic we, input logic [1:0] ch,
                            input logic [2:0] md);
    int mask = (1 << p_w[b]) - 1;
    for (int k = 0; k < p_ch[b]; k++) begin
      bit ea = (e[k] == p_en[b]);
      bit sa = (s[k] == p_sr[b]);
      bit adv = 1'b0;
      bit rs  = 1'b0;
      case (m_mode[b][k])
        0: adv = 1'b1;
        1: adv = ea;
        2: begin adv = 1'b1; rs = sa; end
        3: begin adv = ea;   rs = sa; end
        4: begin adv = ea;   rs = sa && ea; end
        default: ;
      endcase
      if (rs) begin
        for (int i = 0; i < 3; i++) m_st[b][k][i] = p_srv[b];
        m_cnt[b][k] = 0;
      end else if (adv) begin
        for (int i = 2; i > 0; i--) m_st[b][k][i] = m_st[b][k][i-1];
        m_st[b][k][0] = int'(d >> (k * p_w[b])) & mask;
        if (m_cnt[b][k] < p_dep[b]) m_cnt[b][k]++;
      end
    end
    if (we && (int'(ch) < p_ch[b])) m_mode[b][ch] = int'(md);
  endtask

  task automatic compare_bank(input int b, input string tag);
    logic [31:0] xq = '0;
    logic [3:0]  xv = '0;
    logic [11:0] xm = '0;
    for (int k = 0; k < p_ch[b]; k++) begin
      xq = xq | (32'(m_st[b][k][p_dep[b]-1]) << (k * p_w[b]));
      xv[k] = (m_cnt[b][k] >= p_dep[b]);
      xm = xm | (12'(m_mode[b][k]) << (k * 3));
    end
    checks++;
    if (b == 0) begin
      if (q0 !== xq || v0 !== xv || mo0 !== xm[11:0]) begin
        errors++;
        $display("FAIL %s bank0 Q=%h V=%b MODE=%h expected Q=%h V=%b MODE=%h @%0t",
                 tag, q0, v0, mo0, xq, xv, xm, $time);
      end
    end else begin
      if (q1 !== xq[17:0] || v1 !== xv[2:0] || mo1 !== xm[8:0]) begin
        errors++;
        $display("FAIL %s bank1 Q=%h V=%b MODE=%h expected Q=%h V=%b MODE=%h @%0t",
                 tag, q1, v1, mo1, xq[17:0], xv[2:0], xm[8:0], $time);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic test_reset();
    R = 1'b0;
    d0 = '0; e0 = '0; s0 = '0; we0 = 1'b0; ch0 = '0; md0 = '0;
    d1 = '0; e1 = '1; s1 = '1; we1 = 1'b0; ch1 = '0; md1 = '0;
    repeat (3) tick();
    chk("reset_q0",    q0,  32'h0);
    chk("reset_v0",    {28'h0, v0},  32'h0);
    chk("reset_mode0", {20'h0, mo0}, {20'h0, {4{3'd1}}});
    chk("reset_q1",    {14'h0, q1},  {14'h0, {3{6'h15}}});
    chk("reset_v1",    {29'h0, v1},  32'h0);
    chk("reset_mode1", {23'h0, mo1}, 32'h0);
    R = 1'b1;
  endtask

  task automatic test_enable();
    e0 = 4'b0001; d0[7:0] = 8'hA5;
    tick(); tick();
    chk("en_q0_load",  {24'h0, q0[7:0]}, 32'hA5);
    chk("en_v0_load",  {28'h0, v0},      32'h1);
    e0 = 4'b0000; d0[7:0] = 8'h3C;
    repeat (3) tick();
    chk("en_q0_hold",  {24'h0, q0[7:0]}, 32'hA5);
    chk("en_v0_hold",  {31'h0, v0[0]},   32'h1);
  endtask

  task automatic test_srst_priority();
    e0 = 4'b0110; d0[15:8] = 8'h77; d0[23:16] = 8'h99;
    tick(); tick();
    e0 = 4'b0000;
    chk("sp_ch1_load", {24'h0, q0[15:8]}, 32'h77);
    we0 = 1'b1; ch0 = 2'd1; md0 = 3'd3; tick();
    ch0 = 2'd2; md0 = 3'd4; tick();
    we0 = 1'b0;
    chk("sp_mode",     {26'h0, mo0[8:3]}, {26'h0, 3'd4, 3'd3});
    s0 = 4'b0110;
    tick();
    s0 = 4'b0000;
    chk("sp_ch1_rst",  {23'h0, v0[1], q0[15:8]},  {23'h0, 1'b0, 8'h00});
    chk("sp_ch2_keep", {23'h0, v0[2], q0[23:16]}, {23'h0, 1'b1, 8'h99});
    chk("sp_ch0_keep", {24'h0, q0[7:0]}, 32'hA5);
    s0 = 4'b0100; e0 = 4'b0100;
    tick();
    s0 = 4'b0000; e0 = 4'b0000;
    chk("sp_ch2_rst_en", {23'h0, v0[2], q0[23:16]}, 32'h0);
  endtask

  task automatic test_cfg_same_edge();
    we0 = 1'b1; ch0 = 2'd0; md0 = 3'd5; e0 = 4'b0001; d0[7:0] = 8'h11;
    tick();
    we0 = 1'b0;
    chk("cfg_mode5",      {29'h0, mo0[2:0]}, 32'h5);
    chk("cfg_q_oldmode",  {24'h0, q0[7:0]},  32'hA5);
    d0[7:0] = 8'h22;
    tick();
    chk("cfg_frozen",     {23'h0, v0[0], q0[7:0]}, {23'h0, 1'b1, 8'hA5});
    we0 = 1'b1; md0 = 3'd0;
    tick();
    we0 = 1'b0;
    chk("cfg_frozen_edge", {24'h0, q0[7:0]}, 32'hA5);
    d0[7:0] = 8'h33;
    tick();
    chk("cfg_stage0_11",  {24'h0, q0[7:0]}, 32'h11);
    e0 = 4'b0000;
  endtask

  task automatic test_async_mid();
    we0 = 1'b1; ch0 = 2'd3; md0 = 3'd0;
    tick();
    we0 = 1'b0;
    chk("am_mode0", {29'h0, mo0[11:9]}, 32'h0);
    d0[31:24] = 8'h5A;
    tick();
    chk("am_one_adv_v", {31'h0, v0[3]}, 32'h0);
    tick();
    chk("am_two_adv",   {23'h0, v0[3], q0[31:24]}, {23'h0, 1'b1, 8'h5A});
    #2 R = 1'b0;
    #1;
    chk("am_async_q",    q0, 32'h0);
    chk("am_async_v",    {28'h0, v0}, 32'h0);
    chk("am_async_mode", {20'h0, mo0}, {20'h0, {4{3'd1}}});
    @(posedge C);
    #1 R = 1'b1;
    e0 = 4'b1000; d0[31:24] = 8'h66;
    tick();
    chk("am_rel_1edge", {31'h0, v0[3]}, 32'h0);
    tick();
    chk("am_rel_2edge", {23'h0, v0[3], q0[31:24]}, {23'h0, 1'b1, 8'h66});
    e0 = 4'b0000;
  endtask

  task automatic test_random();
    R = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_bank(0, "rnd_reset");
    compare_bank(1, "rnd_reset");
    tick();
    R = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if (n % 2500 == 1249) begin
        R = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_bank(0, "rnd_async");
        compare_bank(1, "rnd_async");
        R = 1'b1;
      end
      d0 = $urandom;
      d1 = 18'($urandom);
      for (int k = 0; k < 4; k++) begin
        bit ea = 1'($urandom_range(0, 1));
        bit sa = ($urandom_range(0, 11) == 0);
        e0[k] = ea; s0[k] = sa;
        if (k < 3) begin
          e1[k] = ~ea; s1[k] = ~sa;
        end
      end
      we0 = ($urandom_range(0, 7) == 0);
      we1 = ($urandom_range(0, 7) == 0);
      ch0 = 2'($urandom_range(0, 3));
      ch1 = 2'($urandom_range(0, 3));
      md0 = 3'($urandom_range(0, 7));
      md1 = 3'($urandom_range(0, 7));
      model_step(0, d0, e0, s0, we0, ch0, md0);
      model_step(1, {14'h0, d1}, {1'b0, e1}, {1'b0, s1}, we1, ch1, md1);
      tick();
      compare_bank(0, "rnd");
      compare_bank(1, "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_srst_priority();
    test_cfg_same_edge();
    test_async_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
